// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default debounce length and the counter sizing helper.
package btn_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t RELEASED     = 2'd0;
    localparam btn_state_t PRESS_WAIT   = 2'd1;
    localparam btn_state_t PRESSED      = 2'd2;
    localparam btn_state_t RELEASE_WAIT = 2'd3;

    // 10 ms at a 100 MHz system clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // The counter only has to reach cycles-1, so clog2(cycles) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: two-flop synchronizer, four-state
// qualification FSM with a saturating stable-level counter, and a press strobe.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    btn_state_t       state;
    btn_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse_next;

    // NOTE: i_btn is asynchronous; only sync may be used, never meta or i_btn.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= i_btn;
            sync <= meta;
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= RELEASED;
            cnt     <= '0;
            o_pulse <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            o_pulse <= pulse_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves a latch behind.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RELEASED: begin
                cnt_next = '0;
                if (sync) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                cnt_next = '0;
                if (!sync) state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    // The strobe is registered on the same edge that enters PRESSED.
    always_comb begin
        o_level    = (state == PRESSED) || (state == RELEASE_WAIT);
        pulse_next = (state == PRESS_WAIT) && (state_next == PRESSED);
    end

endmodule

// File: rtl/btn_debouncer.sv
// Bank of NB_BTN independent debounced buttons; any priority between
// simultaneous presses is left to the consumer of o_pulse.
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned NB_BTN          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_level,
    output logic [NB_BTN-1:0] o_pulse
);

    for (genvar g = 0; g < NB_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clock(i_clock),
            .i_reset(i_reset),
            .i_btn  (i_btn[g]),
            .o_level(o_level[g]),
            .o_pulse(o_pulse[g])
        );
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Self-checking bench for btn_debouncer: directed press/bounce/reset cases
// plus random button traffic, all compared against a run-length reference model.
module tb_btn_debouncer;

    localparam int NB = 4;
    localparam int D  = 4;

    logic          i_clock;
    logic          i_reset;
    logic [NB-1:0] i_btn;
    logic [NB-1:0] o_level;
    logic [NB-1:0] o_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a level flips once the synchronized input has disagreed
    // with it for D+1 consecutive samples; a flip to 1 yields one strobe.
    logic [NB-1:0] samples[$];
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_pulse;
    int            m_run[NB];

    int            edge_n = 0;
    int            pulse_cnt[NB];
    int            pulse_edge[NB];
    int            fall_edge[NB];
    int            all_pulse_cnt;
    logic [NB-1:0] prev_level;

    btn_debouncer #(
        .NB_BTN         (NB),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_btn  (i_btn),
        .o_level(o_level),
        .o_pulse(o_pulse)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        samples.delete();
        m_level    = '0;
        m_pulse    = '0;
        prev_level = '0;
        for (int c = 0; c < NB; c++) m_run[c] = 0;
    endtask

    task automatic model_step();
        logic [NB-1:0] obs;
        samples.push_back(i_btn);
        if (samples.size() > 3) void'(samples.pop_front());
        // The FSM sees the value that was on i_btn two edges earlier.
        obs     = (samples.size() == 3) ? samples[0] : '0;
        m_pulse = '0;
        for (int c = 0; c < NB; c++) begin
            if (obs[c] != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == D + 1) begin
                    m_level[c] = obs[c];
                    m_pulse[c] = obs[c];
                    m_run[c]   = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < NB; c++) begin
            pulse_cnt[c]  = 0;
            pulse_edge[c] = -1000;
            fall_edge[c]  = -1000;
        end
        all_pulse_cnt = 0;
    endtask

    task automatic tick(input logic [NB-1:0] btn);
        i_btn = btn;
        @(posedge i_clock);
        edge_n++;
        model_step();
        #1;
        check("level", 32'(o_level), 32'(m_level));
        check("pulse", 32'(o_pulse), 32'(m_pulse));
        for (int c = 0; c < NB; c++) begin
            if (o_pulse[c]) begin
                pulse_cnt[c]++;
                pulse_edge[c] = edge_n;
            end
            if (prev_level[c] && !o_level[c]) fall_edge[c] = edge_n;
        end
        if (o_pulse == '1) all_pulse_cnt++;
        prev_level = o_level;
    endtask

    task automatic idle(input int n);
        repeat (n) tick('0);
    endtask

    initial begin
        int e0;
        logic [NB-1:0] rnd_btn;

        i_reset = 1'b1;
        i_btn   = '0;
        model_reset();
        clear_stats();

        // Asynchronous reset before any clock edge.
        #2 i_reset = 1'b0;
        #1;
        check("rst_level_noclk", 32'(o_level), 32'd0);
        check("rst_pulse_noclk", 32'(o_pulse), 32'd0);
        @(posedge i_clock);
        @(posedge i_clock);
        #1;
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_pulse", 32'(o_pulse), 32'd0);
        #2 i_reset = 1'b1;

        // Clean press on channel 0, held 20 cycles.
        clear_stats();
        e0 = edge_n + 1;
        repeat (20) tick(4'b0001);
        check("press_count", pulse_cnt[0], 1);
        check("press_latency", pulse_edge[0] - e0 + 1, D + 3);
        check("press_level", 32'(o_level), 32'b0001);
        check("press_others", pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);

        // Release of channel 0.
        e0 = edge_n + 1;
        idle(12);
        check("release_latency", fall_edge[0] - e0 + 1, D + 3);
        check("release_no_pulse", pulse_cnt[0], 1);

        // Short press on channel 1, too brief to qualify.
        clear_stats();
        repeat (3) tick(4'b0010);
        idle(12);
        check("short_pulse", pulse_cnt[1], 0);
        check("short_level", 32'(o_level[1]), 32'd0);

        // Bounce on channel 2, then steady high.
        clear_stats();
        tick(4'b0100); tick(4'b0000); tick(4'b0100); tick(4'b0100); tick(4'b0000);
        e0 = edge_n + 1;
        repeat (15) tick(4'b0100);
        check("bounce_count", pulse_cnt[2], 1);
        check("bounce_latency", pulse_edge[2] - e0 + 1, D + 3);
        idle(12);

        // Simultaneous presses on every channel.
        clear_stats();
        repeat (10) tick(4'b1111);
        check("all_pulse_cycles", all_pulse_cnt, 1);
        check("all_pulse_total", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], NB);
        idle(12);

        // Reset mid-debounce, button held; must requalify with full latency.
        clear_stats();
        repeat (4) tick(4'b0001);
        #2 i_reset = 1'b0;
        #1;
        check("rstdb_level", 32'(o_level), 32'd0);
        check("rstdb_pulse", 32'(o_pulse), 32'd0);
        @(posedge i_clock);
        #1;
        check("rstdb_hold_level", 32'(o_level), 32'd0);
        check("rstdb_hold_pulse", 32'(o_pulse), 32'd0);
        #2 i_reset = 1'b1;
        model_reset();
        e0 = edge_n + 1;
        repeat (10) tick(4'b0001);
        check("rstdb_count", pulse_cnt[0], 1);
        check("rstdb_latency", pulse_edge[0] - e0 + 1, D + 3);
        idle(12);

        // Reset while the press strobe is high.
        clear_stats();
        repeat (D + 3) tick(4'b0001);
        check("rstp_pulse_seen", pulse_cnt[0], 1);
        #2 i_reset = 1'b0;
        #1;
        check("rstp_level", 32'(o_level), 32'd0);
        check("rstp_pulse", 32'(o_pulse), 32'd0);
        #4 i_reset = 1'b1;
        model_reset();
        idle(12);

        // Random traffic: each channel toggles with probability 1/6 per cycle.
        rnd_btn = '0;
        repeat (400) begin
            for (int c = 0; c < NB; c++)
                if ($urandom_range(5) == 0) rnd_btn[c] = ~rnd_btn[c];
            tick(rnd_btn);
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 The block SHALL have parameter NB_BTN, default 4, the number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), the stable-input count required to accept a level change; legal range 2..2^24.
REQ-003 The block SHALL have port i_clock, input, 1 bit, the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port i_btn, input, NB_BTN bits, raw asynchronous button levels, 1 = pressed.
REQ-006 The block SHALL have port o_level, output, NB_BTN bits, the debounced button level per channel.
REQ-007 The block SHALL have port o_pulse, output, NB_BTN bits: one-cycle strobe per accepted press, to drive the downstream load-enable inputs (data A, data B, operation).

Function
REQ-008 Each channel SHALL pass its i_btn bit through a two-flop synchronizer; only the second flop (sync) feeds the channel logic.
REQ-009 Each channel SHALL run a four-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-010 Each channel SHALL contain a counter of width clog2(DEBOUNCE_CYCLES) bits; the counter SHALL never wrap.
REQ-011 In RELEASED with sync=1, the channel SHALL go to PRESS_WAIT with counter=0; with sync=0 it SHALL stay in RELEASED.
REQ-012 In PRESS_WAIT with sync=0, the channel SHALL return to RELEASED and clear the counter.
REQ-013 In PRESS_WAIT with sync=1 and counter<DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-014 In PRESS_WAIT with sync=1 and counter=DEBOUNCE_CYCLES-1, the channel SHALL go to PRESSED and clear the counter.
REQ-015 PRESSED and RELEASE_WAIT SHALL behave as the mirror of RELEASED and PRESS_WAIT, with sync=0 as the qualifying level.
REQ-016 o_level SHALL be 1 exactly while the channel is in PRESSED or RELEASE_WAIT.
REQ-017 o_pulse SHALL be registered and high for exactly one cycle, namely the cycle after the edge on which the channel enters PRESSED.
REQ-018 No o_pulse SHALL be produced on release, nor while the button is held.
REQ-019 Latency: if the first edge sampling i_btn=1 is edge 1 and i_btn is held high, o_pulse SHALL be high in the cycle following edge DEBOUNCE_CYCLES+3.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on o_level or o_pulse.
REQ-021 Channels SHALL be fully independent; simultaneous presses SHALL yield simultaneous pulses on all qualifying channels (priority resolution belongs to the downstream stage).

Reset
REQ-022 While i_reset=0, every channel SHALL be in RELEASED with counter=0, synchronizer flops=0, o_level=0 and o_pulse=0, independent of i_clock.
REQ-023 Reset asserted mid-debounce or mid-pulse SHALL abort immediately; after deassertion, a held button SHALL be re-qualified from RELEASED with the full REQ-019 latency.

Structure
REQ-024 The FSM state encoding (2-bit localparams RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3) SHALL live in a shared package btn_pkg.
REQ-025 The default DEBOUNCE_CYCLES SHALL also live in btn_pkg.
REQ-026 The per-channel logic (synchronizer, FSM, counter, pulse register) SHALL be a sub-module btn_debounce_ch; btn_debouncer SHALL instantiate NB_BTN copies in a generate loop.

Verification (NB_BTN=4, DEBOUNCE_CYCLES=4)
REQ-027 Clean press on i_btn[0] held 20 cycles -> o_pulse[0] high only in the cycle after edge 7; o_level[0]=1 from then on; other outputs stay 0.
REQ-028 i_btn[1] high for 3 cycles, then low -> o_level[1] and o_pulse[1] stay 0 throughout.
REQ-029 Bounce pattern on i_btn[2] (1,0,1,1,0,1 per cycle), then steady 1 -> exactly one o_pulse[2], DEBOUNCE_CYCLES+3 edges after the last 0->1 transition.
REQ-030 Press then release on i_btn[0] -> o_level[0] falls 7 edges after release; no o_pulse on release.
REQ-031 Simultaneous presses on i_btn[3:0]=4'b1111 -> o_pulse=4'b1111 for a single cycle.
REQ-032 i_reset=0 pulsed asynchronously (between clock edges) while channel 0 is in PRESS_WAIT with i_btn[0] held high -> all outputs 0 immediately; after release of reset, pulse arrives after a full 7-edge latency.
